exception_ctrl: RTL and testbench

- CP0-lite exception/interrupt controller for the 5-stage MIPS32 core; it drives the PC register's redirect port.
- Collects synchronous exceptions and ERET from the MEM stage, plus 6 hardware interrupt lines.
- Maintains Status/Cause/EPC and issues a one-cycle pipeline flush with target PC: vector on entry, EPC on ERET.

---
 rtl/cp0_pkg.sv | 28 ++
 rtl/int_sync.sv | 23 ++
 rtl/exception_ctrl.sv | 152 +++++++++++++++
 tb/tb_exception_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, field positions, ExcCodes and controller states
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } cp0_state_t;

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - two-flop synchronizer bank for asynchronous interrupt lines
module int_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - CP0-lite exception/interrupt controller driving the PC redirect port
module exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int          NUM_HW_INT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memValid,
    input  logic [31:0]           memPC,
    input  logic                  memInDelaySlot,
    input  logic                  excValid,
    input  logic [4:0]            excCode,
    input  logic                  eretValid,
    input  logic [NUM_HW_INT-1:0] hwInt,
    input  logic                  cp0WriteEN,
    input  logic [4:0]            cp0Addr,
    input  logic [31:0]           cp0WData,
    output logic [31:0]           cp0RData,
    output logic                  clr,
    output logic                  PCControl,
    output logic [31:0]           ExceptionPC,
    output logic                  excBusy
);

    cp0_state_t state;

    logic [NUM_HW_INT-1:0] hw_sync;
    logic                  st_ie;
    logic                  st_exl;
    logic [7:0]            st_im;
    logic                  ca_bd;
    logic [NUM_HW_INT-1:0] ca_ip_hw;
    logic [1:0]            ca_ip_sw;
    logic [4:0]            ca_exc;
    logic [31:0]           epc;

    logic [7:0]  ca_ip;
    logic [31:0] status_word;
    logic [31:0] cause_word;
    logic        int_pending;
    logic        detect;
    logic        take_exc;
    logic        take_ret;
    logic        event_taken;
    logic [4:0]  code_sel;
    logic [31:0] ret_target;

    int_sync #(.WIDTH(NUM_HW_INT)) u_int_sync (
        .clk      (clk),
        .rst_n    (rst),
        .async_in (hwInt),
        .sync_out (hw_sync)
    );

    assign ca_ip = {ca_ip_hw, ca_ip_sw};

    always_comb begin
        status_word                       = '0;
        status_word[ST_IE]                = st_ie;
        status_word[ST_EXL]               = st_exl;
        status_word[ST_IM_LO +: 8]        = st_im;
        cause_word                        = '0;
        cause_word[CA_BD]                 = ca_bd;
        cause_word[CA_IP_LO +: 8]         = ca_ip;
        cause_word[CA_EXC_LO +: 5]        = ca_exc;
    end

    always_comb begin
        case (cp0Addr)
            CP0_STATUS: cp0RData = status_word;
            CP0_CAUSE:  cp0RData = cause_word;
            CP0_EPC:    cp0RData = epc;
            default:    cp0RData = '0;
        endcase
    end

    // Priority: synchronous exception, then unmasked interrupt, then ERET.
    assign int_pending = st_ie & ~st_exl & (|(ca_ip & st_im));
    assign detect      = (state == IDLE) && memValid;
    assign take_exc    = detect && (excValid || int_pending);
    assign take_ret    = detect && !excValid && !int_pending && eretValid;
    assign event_taken = take_exc || take_ret;
    assign code_sel    = excValid ? excCode : EXC_INT;
    // An EPC write committing alongside ERET still steers the return target.
    assign ret_target  = (cp0WriteEN && cp0Addr == CP0_EPC) ? cp0WData : epc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_ie    <= 1'b0;
            st_exl   <= 1'b0;
            st_im    <= '0;
            ca_bd    <= 1'b0;
            ca_ip_hw <= '0;
            ca_ip_sw <= '0;
            ca_exc   <= '0;
            epc      <= '0;
        end else begin
            ca_ip_hw <= hw_sync;
            if (take_exc) begin
                epc    <= memInDelaySlot ? memPC - 32'd4 : memPC;
                ca_bd  <= memInDelaySlot;
                ca_exc <= code_sel;
                st_exl <= 1'b1;
            end else if (take_ret) begin
                st_exl <= 1'b0;
            end else if (cp0WriteEN) begin
                case (cp0Addr)
                    CP0_STATUS: begin
                        st_ie  <= cp0WData[ST_IE];
                        st_exl <= cp0WData[ST_EXL];
                        st_im  <= cp0WData[ST_IM_LO +: 8];
                    end
                    CP0_CAUSE: ca_ip_sw <= cp0WData[CA_IP_LO +: 2];
                    CP0_EPC:   epc      <= cp0WData;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            clr         <= 1'b0;
            PCControl   <= 1'b0;
            ExceptionPC <= '0;
            excBusy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (event_taken) begin
                        state       <= REDIRECT;
                        clr         <= 1'b1;
                        PCControl   <= 1'b1;
                        excBusy     <= 1'b1;
                        ExceptionPC <= take_exc ? EXC_VECTOR : ret_target;
                    end
                end
                REDIRECT: begin
                    state     <= IDLE;
                    clr       <= 1'b0;
                    PCControl <= 1'b0;
                    excBusy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - scoreboard bench for exception_ctrl with a behavioural CP0 model
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst;
    logic        memValid;
    logic [31:0] memPC;
    logic        memInDelaySlot;
    logic        excValid;
    logic [4:0]  excCode;
    logic        eretValid;
    logic [5:0]  hwInt;
    logic        cp0WriteEN;
    logic [4:0]  cp0Addr;
    logic [31:0] cp0WData;
    logic [31:0] cp0RData;
    logic        clr;
    logic        PCControl;
    logic [31:0] ExceptionPC;
    logic        excBusy;

    exception_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .memValid       (memValid),
        .memPC          (memPC),
        .memInDelaySlot (memInDelaySlot),
        .excValid       (excValid),
        .excCode        (excCode),
        .eretValid      (eretValid),
        .hwInt          (hwInt),
        .cp0WriteEN     (cp0WriteEN),
        .cp0Addr        (cp0Addr),
        .cp0WData       (cp0WData),
        .cp0RData       (cp0RData),
        .clr            (clr),
        .PCControl      (PCControl),
        .ExceptionPC    (ExceptionPC),
        .excBusy        (excBusy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: register fields, interrupt arrival delay and pending redirects.
    logic        m_ie, m_exl, m_bd, m_redir;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_last_target, m_tgt;
    logic [5:0]  hq0, hq1, m_new_hw;
    logic        m_pend, m_take_e, m_take_r;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'h0, m_ip, 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ie = 0; m_exl = 0; m_bd = 0; m_redir = 0;
            m_im = 0; m_ip = 0; m_exc = 0; m_epc = 0; m_last_target = 0;
            hq0 = 0; hq1 = 0;
            exp_q.delete();
        end else begin
            m_pend   = m_ie && !m_exl && ((m_ip & m_im) != 8'h0);
            m_take_e = 1'b0;
            m_take_r = 1'b0;
            if (m_redir)
                m_redir = 1'b0;
            else if (memValid) begin
                if (excValid || m_pend) m_take_e = 1'b1;
                else if (eretValid)     m_take_r = 1'b1;
            end
            m_new_hw = hq1;
            hq1 = hq0;
            hq0 = hwInt;
            if (m_take_e) begin
                m_epc = memInDelaySlot ? memPC - 32'd4 : memPC;
                m_bd  = memInDelaySlot;
                m_exc = excValid ? excCode : 5'd0;
                m_exl = 1'b1;
                m_tgt = VEC;
            end else if (m_take_r) begin
                m_exl = 1'b0;
                m_tgt = (cp0WriteEN && cp0Addr == 5'd14) ? cp0WData : m_epc;
            end else if (cp0WriteEN) begin
                if (cp0Addr == 5'd12) begin
                    m_ie  = cp0WData[0];
                    m_exl = cp0WData[1];
                    m_im  = cp0WData[15:8];
                end else if (cp0Addr == 5'd13) begin
                    m_ip[1:0] = cp0WData[9:8];
                end else if (cp0Addr == 5'd14) begin
                    m_epc = cp0WData;
                end
            end
            if (m_take_e || m_take_r) begin
                exp_q.push_back(m_tgt);
                m_last_target = m_tgt;
                m_redir = 1'b1;
            end
            m_ip[7:2] = m_new_hw;
        end
    end

    logic [31:0] exp_pc;
    always @(negedge clk) begin
        if (rst) begin
            check("cp0_rdata", cp0RData, m_read(cp0Addr));
            if (exp_q.size() > 0) begin
                exp_pc = exp_q.pop_front();
                check("clr_pulse", {31'h0, clr}, 32'h1);
                check("pc_control", {31'h0, PCControl}, 32'h1);
                check("exc_busy", {31'h0, excBusy}, 32'h1);
                check("exception_pc", ExceptionPC, exp_pc);
                pulse_cnt++;
            end else begin
                check("clr_idle", {31'h0, clr}, 32'h0);
                check("busy_idle", {31'h0, excBusy}, 32'h0);
                check("exception_pc_hold", ExceptionPC, m_last_target);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        memValid = 0; excValid = 0; eretValid = 0; memInDelaySlot = 0;
        cp0WriteEN = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0WriteEN = 1; cp0Addr = a; cp0WData = d;
        step();
        cp0WriteEN = 0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        cp0Addr = a;
        #1;
        check(name, cp0RData, exp);
    endtask

    task automatic raise_exc(input logic [31:0] pc, input logic ds, input logic [4:0] code);
        memValid = 1; excValid = 1; excCode = code; memPC = pc; memInDelaySlot = ds;
        step();
        idle_in();
    endtask

    logic [4:0] codes [7];
    int         cnt0;
    logic [31:0] rv;

    initial begin
        codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
        rst = 0; hwInt = 0; memPC = 0; excCode = 0; cp0Addr = 0; cp0WData = 0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        check("rst_clr", {31'h0, clr}, 32'h0);
        check("rst_pcc", {31'h0, PCControl}, 32'h0);
        check("rst_epc_out", ExceptionPC, 32'h0);
        rd("rst_status", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        @(posedge clk);
        #1 rst = 1;
        step();

        raise_exc(32'h0000_1000, 1'b0, 5'd12);
        check("ovf_clr", {31'h0, clr}, 32'h1);
        check("ovf_target", ExceptionPC, VEC);
        step();
        check("ovf_clr_end", {31'h0, clr}, 32'h0);
        check("ovf_pc_hold", ExceptionPC, VEC);
        rd("ovf_epc", 5'd14, 32'h0000_1000);
        rd("ovf_cause", 5'd13, 32'h0000_0030);
        rd("ovf_status", 5'd12, 32'h0000_0002);

        memValid = 1; eretValid = 1;
        step();
        idle_in();
        check("eret_target", ExceptionPC, 32'h0000_1000);
        check("eret_clr", {31'h0, clr}, 32'h1);
        step();
        rd("eret_status", 5'd12, 32'h0);

        raise_exc(32'h0000_2004, 1'b1, 5'd12);
        step();
        rd("ds_epc", 5'd14, 32'h0000_2000);
        rd("ds_cause", 5'd13, 32'h8000_0030);

        mtc0(5'd12, 32'h0000_0401);
        hwInt = 6'b000001; memValid = 1; memPC = 32'h0000_0300;
        cnt0 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (clr) break;
            cnt0++;
        end
        memValid = 0; hwInt = 0;
        check("int_latency_ok", {31'h0, (cnt0 < 8)}, 32'h1);
        check("int_target", ExceptionPC, VEC);
        step();
        rd("int_epc", 5'd14, 32'h0000_0300);
        rd("int_code", 5'd13, {16'h0, 8'h04, 8'h00});

        mtc0(5'd12, 32'h0000_0400);
        cnt0 = pulse_cnt;
        hwInt = 6'b000001; memValid = 1;
        repeat (8) step();
        memValid = 0; hwInt = 0;
        check("ie0_no_redirect", pulse_cnt - cnt0, 0);
        repeat (4) step();

        cnt0 = pulse_cnt;
        memValid = 1; excValid = 1; excCode = 5'd12; memPC = 32'h0000_4444;
        cp0WriteEN = 1; cp0Addr = 5'd14; cp0WData = 32'hDEAD_BEEF;
        step();
        cp0WriteEN = 0;
        step();
        idle_in();
        step();
        check("collision_one_pulse", pulse_cnt - cnt0, 1);
        rd("collision_epc", 5'd14, 32'h0000_4444);

        raise_exc(32'h0000_5000, 1'b0, 5'd10);
        #2 rst = 0;
        #1;
        check("arst_clr", {31'h0, clr}, 32'h0);
        check("arst_pcc", {31'h0, PCControl}, 32'h0);
        check("arst_pc", ExceptionPC, 32'h0);
        check("arst_busy", {31'h0, excBusy}, 32'h0);
        rd("arst_status", 5'd12, 32'h0);
        rd("arst_cause", 5'd13, 32'h0);
        rd("arst_epc", 5'd14, 32'h0);
        @(posedge clk);
        #1 rst = 1;
        step();

        for (int c = 0; c < 3000; c++) begin
            memValid       = ($urandom_range(0, 3) != 0);
            memPC          = {$urandom, 2'b00} + 32'h0;
            memInDelaySlot = $urandom_range(0, 1);
            excValid       = ($urandom_range(0, 7) == 0);
            excCode        = codes[$urandom_range(0, 6)];
            eretValid      = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) hwInt = 6'($urandom);
            cp0WriteEN     = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: cp0Addr = 5'd12;
                1: cp0Addr = 5'd13;
                2: cp0Addr = 5'd14;
                default: cp0Addr = 5'($urandom);
            endcase
            rv = $urandom;
            cp0WData = rv;
            step();
        end
        idle_in();
        hwInt = 0;
        repeat (6) step();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
